// File: rtl/cp0_regfile_if.sv
// Writeback-stage <-> CP0 link: retiring instruction info in, mfc0 data and flush/redirect out.
interface cp0_regfile_if;
  logic [8:0]  c0_exception;
  logic [4:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic        c0_wb_valid;
  logic        c0_wb_bd;
  logic [31:0] c0_wb_pc;
  logic [31:0] ws_badvaddr;
  logic        c0_wb_int;
  logic        c0_valid;
  logic [31:0] c0_res;
  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    output c0_exception, c0_addr, c0_wdata, c0_wb_valid, c0_wb_bd,
           c0_wb_pc, ws_badvaddr, c0_wb_int,
    input  c0_valid, c0_res, flush, flush_pc
  );

  modport slave (
    input  c0_exception, c0_addr, c0_wdata, c0_wb_valid, c0_wb_bd,
           c0_wb_pc, ws_badvaddr, c0_wb_int,
    output c0_valid, c0_res, flush, flush_pc
  );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr/Count/Compare/Status/Cause/EPC,
// exception/eret flush generation, timer interrupt and interrupt-pending flag.
module cp0_regfile #(
  parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        reset,
  cp0_regfile_if.slave wb,
  input  logic [5:0]  ext_int_in,
  output logic        has_int
);
  logic sys, mfc0, mtc0, eret, brk, ov, adel, ades, ri;
  assign {sys, mfc0, mtc0, eret, brk, ov, adel, ades, ri} = wb.c0_exception;

  logic        exc, ert, wr;
  logic [4:0]  exc_code;

  logic        tick;
  logic [31:0] count, compare, epc, badvaddr;
  logic [7:0]  status_im;
  logic        status_exl, status_ie;
  logic        cause_bd, cause_ti;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc;
  logic [31:0] status_val, cause_val;

  assign exc = wb.c0_wb_valid & (wb.c0_wb_int | sys | brk | ov | adel | ades | ri);
  assign ert = wb.c0_wb_valid & eret & ~exc;
  assign wr  = wb.c0_wb_valid & mtc0 & ~exc;

  assign wb.flush    = exc | ert;
  assign wb.flush_pc = ert ? epc : EX_ENTRY;
  assign wb.c0_valid = wb.c0_wb_valid & mfc0 & ~exc;

  assign status_val = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_val  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw,
                       1'b0, cause_exc, 2'b0};

  assign has_int = status_ie & ~status_exl &
                   (|({cause_ip_hw, cause_ip_sw} & status_im));

  always_comb begin
    exc_code = 5'd0;
    if (wb.c0_wb_int) exc_code = 5'd0;
    else if (adel)    exc_code = 5'd4;
    else if (ri)      exc_code = 5'd10;
    else if (ov)      exc_code = 5'd12;
    else if (sys)     exc_code = 5'd8;
    else if (brk)     exc_code = 5'd9;
    else if (ades)    exc_code = 5'd5;
  end

  always_comb begin
    wb.c0_res = '0;
    case (wb.c0_addr)
      5'd8:    wb.c0_res = badvaddr;
      5'd9:    wb.c0_res = count;
      5'd11:   wb.c0_res = compare;
      5'd12:   wb.c0_res = status_val;
      5'd13:   wb.c0_res = cause_val;
      5'd14:   wb.c0_res = epc;
      default: wb.c0_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick        <= 1'b0;
      count       <= '0;
      compare     <= '0;
      epc         <= '0;
      badvaddr    <= '0;
      status_im   <= '0;
      status_exl  <= 1'b0;
      status_ie   <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ti    <= 1'b0;
      cause_ip_hw <= '0;
      cause_ip_sw <= '0;
      cause_exc   <= '0;
    end else begin
      tick <= ~tick;

      if (wr && wb.c0_addr == 5'd9) count <= wb.c0_wdata;
      else if (tick)                count <= count + 32'd1;

      if (wr && wb.c0_addr == 5'd11) begin
        compare  <= wb.c0_wdata;
        cause_ti <= 1'b0;
      end else if (count == compare) begin
        cause_ti <= 1'b1;
      end

      cause_ip_hw <= {ext_int_in[5] | cause_ti, ext_int_in[4:0]};

      if (wr && wb.c0_addr == 5'd12) begin
        status_im  <= wb.c0_wdata[15:8];
        status_exl <= wb.c0_wdata[1];
        status_ie  <= wb.c0_wdata[0];
      end
      if (wr && wb.c0_addr == 5'd13) cause_ip_sw <= wb.c0_wdata[9:8];
      if (wr && wb.c0_addr == 5'd14) epc <= wb.c0_wdata;

      // Placed after the mtc0 writes so exception/eret updates win on shared fields.
      if (exc) begin
        if (!status_exl) begin
          epc      <= wb.c0_wb_bd ? wb.c0_wb_pc - 32'd4 : wb.c0_wb_pc;
          cause_bd <= wb.c0_wb_bd;
        end
        status_exl <= 1'b1;
        cause_exc  <= exc_code;
        if (exc_code == 5'd4 || exc_code == 5'd5) badvaddr <= wb.ws_badvaddr;
      end else if (ert) begin
        status_exl <= 1'b0;
      end
    end
  end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file and exception controller.
- Responder end of the writeback-stage CP0 interface.
- Each cycle it accepts the retiring instruction's exception, mtc0, mfc0 and eret information. It updates BadVAddr/Count/Compare/Status/Cause/EPC, returns mfc0 read data, and raises the pipeline-wide flush with the redirect PC.
- Also generates the timer interrupt and the interrupt-pending flag consumed by decode.

Parameters:
EX_ENTRY, 32'hBFC0_0380, exception vector driven on flush_pc for all non-eret flushes

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
c0_exception  in  9  {sys,mfc0,mtc0,eret,break,ov,adel,ades,ri} of WB instruction
c0_addr  in  5  CP0 register number (rd) for mtc0/mfc0
c0_wdata  in  32  mtc0 write data
c0_wb_valid  in  1  WB holds a valid instruction
c0_wb_bd  in  1  WB instruction is in a delay slot
c0_wb_pc  in  32  WB instruction PC
ws_badvaddr  in  32  faulting address for adel/ades
c0_wb_int  in  1  WB instruction was tagged interrupted at decode
ext_int_in  in  6  hardware interrupt lines, level, active-high
c0_valid  out  1  mfc0 result valid this cycle
c0_res  out  32  mfc0 read data
flush  out  1  flush all stages this cycle
flush_pc  out  32  fetch redirect target when flush=1
has_int  out  1  interrupt pending and enabled (to decode)

Behaviour:
- Interface contract:
  - Clock port is clk; reset port is reset, synchronous, active-high. All state updates on posedge clk.
  - Outputs c0_valid, c0_res, flush, flush_pc and has_int are combinational from registers and inputs.
- Register map (c0_addr): 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other address reads 0; writes to it are ignored.
- Register fields:
  - Status: BEV[22] is read-only 1, IM[15:8] rw, EXL[1] rw, IE[0] rw. All other bits read 0.
  - Cause: BD[31] ro, TI[30] ro, IP[15:10] ro (hardware), IP[9:8] rw (software), ExcCode[6:2] ro. All other bits read 0.
- Reset values: Status=32'h0040_0000; Cause, EPC, BadVAddr, Count, Compare = 0; internal tick = 0. Outputs under reset follow these values, so flush=0 when c0_wb_valid=0.
- Exception detection:
  - exc = c0_wb_valid & (c0_wb_int | sys | break | ov | adel | ades | ri).
  - ert = c0_wb_valid & eret & ~exc.
  - flush = exc | ert.
  - flush_pc = ert ? EPC : EX_ENTRY.
- ExcCode priority (highest first): int 0, adel 4, ri 10, ov 12, sys 8, break 9, ades 5.
- On exc:
  - If EXL=0: EPC <= c0_wb_bd ? c0_wb_pc-4 : c0_wb_pc, and Cause.BD <= c0_wb_bd.
  - If EXL=1: EPC and BD are unchanged.
  - Always: EXL <= 1 and ExcCode <= selected code.
  - BadVAddr <= ws_badvaddr only when the selected code is 4 or 5.
- On ert: EXL <= 0; nothing else changes.
- mtc0: write happens only when c0_wb_valid & mtc0 & ~exc. An exception or eret update to the same field in the same cycle wins.
- mfc0: c0_valid = c0_wb_valid & mfc0 & ~exc. c0_res is the current registered value, with no same-cycle write bypass.
- Timer:
  - tick toggles every cycle; Count increments (wraps at 2^32) on cycles where tick=1.
  - mtc0 Count loads c0_wdata and overrides the increment.
  - mtc0 Compare loads Compare and clears TI the same edge; TI set takes lower priority.
  - Otherwise TI <= 1 when Count==Compare (registered values); TI stays set until a Compare write.
- Hardware interrupt sampling: Cause.IP[15:10] <= {ext_int_in[5]|TI, ext_int_in[4:0]} every cycle.
- has_int = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]).

Test Plan:
- Reset, then idle -> Status reads 32'h0040_0000; Count reads 3 after 6 or 7 idle cycles (tick phase); flush=0.
- Syscall at pc=32'hBFC0_1000, bd=0, EXL=0 -> flush=1, flush_pc=32'hBFC0_0380; next cycle EPC=32'hBFC0_1000, ExcCode=8, EXL=1.
- adel in delay slot, pc=32'h8000_0104, badvaddr=32'h8000_0003 -> EPC=32'h8000_0100, BD=1, BadVAddr=32'h8000_0003, ExcCode=4. Then eret -> flush_pc=32'h8000_0100 and EXL=0 next cycle.
- Second exception (ov) with EXL=1 -> EPC and BD unchanged, ExcCode=12.
- mtc0 Compare=5, Status=32'h0000_8001 -> TI and IP7 set when Count=5, has_int=1. mtc0 Compare=100 -> TI=0 next cycle.
- mtc0 Status carrying sys -> write suppressed, Status changes only via exception. mfc0 Cause with ri -> c0_valid=0.
